// File: rtl/bloom_filter_bram_ctrl.sv
// Bloom bitmap controller: query/insert/clear of a 2048-bit bitmap held in a 64x32 BRAM.
// Optional BLOOM_FILL_COUNT_EN adds a fill_count port tracking the number of set bits.
module bloom_filter_bram_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [10:0] hash_0,
  input  logic [10:0] hash_1,
  input  logic [10:0] hash_2,
  input  logic [10:0] hash_3,
  input  logic [10:0] hash_4,
  input  logic [10:0] hash_5,
  input  logic [10:0] hash_6,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_hit
`ifdef BLOOM_FILL_COUNT_EN
  ,
  output logic [11:0] fill_count
`endif
);

  localparam int unsigned K     = 7;
  localparam int unsigned IdxW  = 11;
  localparam int unsigned Words = 64;

  typedef enum logic [2:0] {StIdle, StRd, StEval, StClr, StResp} state_e;

  state_e           state_q, state_d;
  logic             ins_q, ins_d;
  logic [IdxW-1:0]  hash_q [K];
  logic [IdxW-1:0]  hash_d [K];
  logic [IdxW-1:0]  hash_in [K];
  logic [2:0]       k_q, k_d;
  logic [5:0]       n_q, n_d;
  logic             hit_q, hit_d;
  logic [IdxW-1:0]  cur_idx;

  logic [31:0]      mem [Words];
  logic [31:0]      rd_data;
  logic             mem_re, mem_we;
  logic [5:0]       mem_raddr, mem_waddr;
  logic [31:0]      mem_wdata;

  assign hash_in[0] = hash_0;
  assign hash_in[1] = hash_1;
  assign hash_in[2] = hash_2;
  assign hash_in[3] = hash_3;
  assign hash_in[4] = hash_4;
  assign hash_in[5] = hash_5;
  assign hash_in[6] = hash_6;

  assign cur_idx = hash_q[k_q];

  // Bitmap RAM is intentionally not reset; a clear command initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (mem_re) begin
      rd_data <= mem[mem_raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ins_q   <= 1'b0;
      k_q     <= '0;
      n_q     <= '0;
      hit_q   <= 1'b0;
      for (int i = 0; i < K; i++) begin
        hash_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ins_q   <= ins_d;
      k_q     <= k_d;
      n_q     <= n_d;
      hit_q   <= hit_d;
      hash_q  <= hash_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ins_d     = ins_q;
    hash_d    = hash_q;
    k_d       = k_q;
    n_d       = n_q;
    hit_d     = hit_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_raddr = cur_idx[10:5];
    mem_waddr = cur_idx[10:5];
    mem_wdata = rd_data | (32'd1 << cur_idx[4:0]);

    unique case (state_q)
      StIdle: begin
        cmd_ready = ~rst;
        if (cmd_valid) begin
          ins_d   = (cmd_op == 2'b01);
          hash_d  = hash_in;
          k_d     = '0;
          n_d     = '0;
          hit_d   = 1'b1;
          state_d = (cmd_op == 2'b10) ? StClr : StRd;
        end
      end
      StRd: begin
        mem_re  = 1'b1;
        state_d = StEval;
      end
      StEval: begin
        // Write-back lands before the next RD, so same-word indices see updated data.
        hit_d  = hit_q & rd_data[cur_idx[4:0]];
        mem_we = ins_q;
        if (k_q == 3'(K - 1)) begin
          state_d = StResp;
        end else begin
          k_d     = 3'(k_q + 3'd1);
          state_d = StRd;
        end
      end
      StClr: begin
        mem_we    = 1'b1;
        mem_waddr = n_q;
        mem_wdata = '0;
        n_d       = 6'(n_q + 6'd1);
        if (n_q == 6'(Words - 1)) begin
          hit_d   = 1'b0;
          state_d = StResp;
        end
      end
      StResp: begin
        rsp_valid = ~rst;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rsp_hit = rsp_valid & hit_q;

`ifdef BLOOM_FILL_COUNT_EN
  logic [11:0] fill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
    end else if (state_q == StClr && n_q == 6'(Words - 1)) begin
      fill_q <= '0;
    end else if (state_q == StEval && ins_q && !rd_data[cur_idx[4:0]]) begin
      fill_q <= 12'(fill_q + 12'd1);
    end
  end

  assign fill_count = fill_q;
`endif

endmodule

// File: tb/tb_bloom_filter_bram_ctrl.sv
// Self-checking bench for bloom_filter_bram_ctrl: directed plan plus randomized commands
// checked against a bit-array model of the bitmap.
module tb_bloom_filter_bram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [10:0] hv [7];
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_hit;
`ifdef BLOOM_FILL_COUNT_EN
  logic [11:0] fill_count;
`endif

  int checks = 0;
  int passes = 0;
  bit bm [2048];
  int model_fill = 0;

  always #5 clk = ~clk;

  bloom_filter_bram_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .hash_0    (hv[0]),
    .hash_1    (hv[1]),
    .hash_2    (hv[2]),
    .hash_3    (hv[3]),
    .hash_4    (hv[4]),
    .hash_5    (hv[5]),
    .hash_6    (hv[6]),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_hit   (rsp_hit)
`ifdef BLOOM_FILL_COUNT_EN
    ,
    .fill_count(fill_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_fill(input string tag);
`ifdef BLOOM_FILL_COUNT_EN
    check({tag, "_fill"}, 32'(fill_count), model_fill);
`endif
  endtask

  task automatic set_hashes(input logic [10:0] a, b, c, d, e, f, g);
    hv[0] = a; hv[1] = b; hv[2] = c; hv[3] = d; hv[4] = e; hv[5] = f; hv[6] = g;
  endtask

  // Issues one command, checks latency, hit, back-pressure hold and return to idle.
  task automatic run_cmd(input logic [1:0] op, input int hold, input string tag);
    int   lat;
    int   exp_lat;
    logic exp_hit;
    bit   busy_ready;
    logic [10:0] saved [7];
    exp_hit = (op != 2'b10);
    if (op != 2'b10) begin
      for (int i = 0; i < 7; i++) if (!bm[hv[i]]) exp_hit = 1'b0;
    end
    exp_lat = (op == 2'b10) ? 65 : 15;
    saved = hv;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    rsp_ready = (hold == 0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    for (int i = 0; i < 7; i++) hv[i] = 11'($urandom);
    lat = 0;
    busy_ready = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (!rsp_valid && cmd_ready) busy_ready = 1'b1;
    end while (!rsp_valid && lat < 200);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_ready"}, 32'(busy_ready), 0);
    check({tag, "_hit"}, 32'(rsp_hit), 32'(exp_hit));
    if (op == 2'b10) begin
      for (int i = 0; i < 2048; i++) bm[i] = 1'b0;
    end else if (op == 2'b01) begin
      for (int i = 0; i < 7; i++) bm[saved[i]] = 1'b1;
    end
    model_fill = 0;
    for (int i = 0; i < 2048; i++) model_fill += int'(bm[i]);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, 32'(rsp_valid), 1);
      check({tag, "_hold_hit"}, 32'(rsp_hit), 32'(exp_hit));
      check({tag, "_hold_cmd_ready"}, 32'(cmd_ready), 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_done_valid"}, 32'(rsp_valid), 0);
    check({tag, "_done_cmd_ready"}, 32'(cmd_ready), 1);
    check_fill(tag);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    rsp_ready = 1'b1;
    set_hashes(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_hit", 32'(rsp_hit), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 1);
    check("post_rst_rsp_valid", 32'(rsp_valid), 0);
    model_fill = 0;
    check_fill("post_rst");

    // Directed plan
    run_cmd(2'b10, 0, "clr0");
    set_hashes(11'h000, 11'h021, 11'h142, 11'h263, 11'h384, 11'h4A5, 11'h7FF);
    run_cmd(2'b00, 0, "q_empty");
    set_hashes(11'h000, 11'h021, 11'h142, 11'h263, 11'h384, 11'h4A5, 11'h7FF);
    run_cmd(2'b01, 0, "ins7");
    check("ins7_model_fill", model_fill, 7);
    set_hashes(11'h000, 11'h021, 11'h142, 11'h263, 11'h384, 11'h4A5, 11'h7FF);
    run_cmd(2'b00, 0, "q_hit");
    set_hashes(11'h000, 11'h021, 11'h142, 11'h263, 11'h384, 11'h4A5, 11'h7FF);
    run_cmd(2'b01, 0, "reins");
    set_hashes(11'h000, 11'h021, 11'h142, 11'h263, 11'h384, 11'h4A5, 11'h555);
    run_cmd(2'b00, 0, "q_six");
    set_hashes(11'h000, 11'h021, 11'h142, 11'h263, 11'h384, 11'h4A5, 11'h7FF);
    run_cmd(2'b11, 0, "q_rsvd");
    run_cmd(2'b10, 0, "clr1");
    set_hashes(11'h3E7, 11'h3E7, 11'h3E7, 11'h3E7, 11'h3E7, 11'h3E7, 11'h3E7);
    run_cmd(2'b01, 0, "ins_dup");
    set_hashes(11'h3E7, 11'h3E7, 11'h3E7, 11'h3E7, 11'h3E7, 11'h3E7, 11'h3E7);
    run_cmd(2'b00, 5, "q_dup_bp");

    // Reset in the middle of an insert
    set_hashes(11'h011, 11'h122, 11'h233, 11'h344, 11'h455, 11'h566, 11'h677);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_cmd_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("after_rst_cmd_ready", 32'(cmd_ready), 1);
    check("after_rst_rsp_valid", 32'(rsp_valid), 0);
    model_fill = 0;
    check_fill("after_rst");
    run_cmd(2'b10, 0, "clr_after_rst");
    set_hashes(11'h011, 11'h122, 11'h233, 11'h344, 11'h455, 11'h566, 11'h677);
    run_cmd(2'b00, 0, "q_after_rst");

    // Randomized commands against the bitmap model
    for (int n = 0; n < 40; n++) begin
      int r;
      logic [1:0] op;
      r = $urandom_range(0, 19);
      if (r == 0) op = 2'b10;
      else if (r < 9) op = 2'b01;
      else if (r < 17) op = 2'b00;
      else op = 2'b11;
      for (int i = 0; i < 7; i++) begin
        if ($urandom_range(0, 1) == 1) hv[i] = 11'($urandom_range(0, 15) * 131);
        else hv[i] = 11'($urandom_range(0, 2047));
      end
      run_cmd(op, $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bloom_filter_bram_ctrl.md
# bloom_filter_bram_ctrl

Downstream consumer of the 7-way 11-bit Bloom hash generator. Takes one set of seven 11-bit bit indices per command and performs a query, insert, or clear on a 2048-bit Bloom bitmap held in an internal 64×32 block RAM. Commands are accepted with a valid/ready handshake, and one response per command is returned with a valid/ready handshake. The block sits between the hash stage and the packet-filter decision logic.

## Interface
- `K`, 7, number of hash indices per command; fixed, not overridable.
- `IDX_W`, 11, index width: `addr = idx[10:5]` (word), `bit = idx[4:0]`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command; high only in IDLE.
- `cmd_op`  in  2  command opcode:
  - 00: query.
  - 01: insert.
  - 10: clear.
  - 11: reserved, executed as query.
- `hash_0` … `hash_6`  in  11 each  bit indices, sampled on handshake.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_hit`  out  1  all seven indexed bits were 1 when read.
- `fill_count`  out  12  count of bitmap bits set; present only with `BLOOM_FILL_COUNT_EN`.

## Operation
- FSM states: IDLE, RD, EVAL, CLR, RESP.
- IDLE
  - `cmd_ready` = 1.
  - On `cmd_valid & cmd_ready`: latch `cmd_op` and all hashes, set `k` = 0, set `hit_acc` = 1.
  - Go to RD for query/insert/reserved; go to CLR (word counter = 0) for clear.
- RD
  - Drive the BRAM read address with `hash_k[10:5]`.
  - Go to EVAL.
- EVAL
  - BRAM data is valid in this cycle (1-cycle read latency).
  - `hit_acc &= word[hash_k[4:0]]`.
  - On insert: write `word | (1 << hash_k[4:0])` back to the same address in this cycle.
  - If `k` = 6: go to RESP. Otherwise increment `k` and go to RD.
- Hazards: the write for index k completes before the read for index k+1 is issued, so duplicate or same-word indices need no forwarding logic.
- CLR
  - Write 0 to word `n` for n = 0..63, one word per cycle.
  - After word 63: `rsp_hit` = 0, go to RESP.
- RESP
  - `rsp_valid` = 1; `rsp_hit` = `hit_acc`, or 0 after a clear.
  - Return to IDLE on `rsp_ready`.
  - `rsp_hit` is stable while `rsp_valid` is high.
- Insert semantics: `rsp_hit` reflects the bitmap state before the insert. A result of 1 means the element was already (possibly) present.
- Reset
  - Forces IDLE and aborts any operation in progress.
  - A partially completed insert leaves the bits already written set.
  - BRAM contents are NOT cleared by `rst`. Software or the bench must issue a clear command after power-up.

## Timing
- Reset values:
  - `cmd_ready` = 1 in the cycle after `rst` deasserts; `cmd_ready` = 0 while `rst` is high.
  - `rsp_valid` = 0, `rsp_hit` = 0, `fill_count` = 0.
- Query/insert, with the handshake at cycle 0:
  - RD/EVAL pairs occupy cycles 1–14.
  - `rsp_valid` rises at cycle 15.
  - With `rsp_ready` = 1, the next command can be accepted at cycle 16.
- Clear: handshake at cycle 0, writes occupy cycles 1–64, `rsp_valid` rises at cycle 65.
- Back-pressure: while `rsp_ready` = 0, the block holds RESP indefinitely and `cmd_ready` stays 0.
- There is no command pipelining: exactly one command is in flight at a time.

## Configuration
- Macro: `BLOOM_FILL_COUNT_EN`.
- When defined:
  - The `fill_count` port and a 12-bit counter are present.
  - The counter increments in each insert EVAL cycle where the addressed bit was 0 before the write.
  - It resets to 0 on `rst` or on completion of a clear.
  - Maximum value is 2048; it never wraps, by construction.
- When undefined: the port and the counter are absent, and all other behaviour is identical.

## Test plan
- Clear then query with hashes 0x000,0x021,0x142,0x263,0x384,0x4A5,0x7FF → `rsp_valid` at cycle 15, `rsp_hit` = 0, `fill_count` = 0.
- Insert the same seven indices → `rsp_hit` = 0, `fill_count` = 7. A following query of the same indices → `rsp_hit` = 1.
- Re-insert the same indices → `rsp_hit` = 1 and `fill_count` stays 7.
- Query with six matching indices plus 0x555 → `rsp_hit` = 0.
- After a clear, insert with all seven hashes = 0x3E7 (same bit) → `fill_count` = 1 and `rsp_hit` = 0. A following query → `rsp_hit` = 1.
- Back-pressure and reset:
  - Hold `rsp_ready` = 0 for 5 cycles → `rsp_valid` and `rsp_hit` are held and `cmd_ready` stays 0. The response is consumed on the first `rsp_ready` cycle.
  - Assert `rst` during cycle 6 of an insert → IDLE next cycle, `fill_count` = 0.
  - Then clear + query → `rsp_hit` = 0 at cycle 65 and cycle 15 respectively.
